// File: rtl/vrf_xor_mp_if.sv
// Operand-fetch / writeback port bundle of the XOR-banked lane vector register file.
interface vrf_xor_mp_if #(
    parameter int unsigned R_PORTS_NUM = 4,
    parameter int unsigned W_PORTS_NUM = 2,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned MEM_WIDTH   = 32
);
    localparam int unsigned NUM_OF_BYTES = MEM_WIDTH / 8;
    localparam int unsigned AW           = $clog2(MEM_DEPTH);

    logic [R_PORTS_NUM-1:0][AW-1:0]           raddr_i;
    logic [R_PORTS_NUM-1:0]                   ren_i;
    logic [R_PORTS_NUM-1:0][MEM_WIDTH-1:0]    dout_o;
    logic [R_PORTS_NUM-1:0]                   rvalid_o;
    logic [W_PORTS_NUM-1:0][AW-1:0]           waddr_i;
    logic [W_PORTS_NUM-1:0]                   wen_i;
    logic [W_PORTS_NUM-1:0][NUM_OF_BYTES-1:0] bwe_i;
    logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0]    din_i;
    logic                                     init_done_o;
    logic [W_PORTS_NUM-1:0]                   wcollision_o;

    modport master (
        output raddr_i, ren_i, waddr_i, wen_i, bwe_i, din_i,
        input  dout_o, rvalid_o, init_done_o, wcollision_o
    );

    modport slave (
        input  raddr_i, ren_i, waddr_i, wen_i, bwe_i, din_i,
        output dout_o, rvalid_o, init_done_o, wcollision_o
    );
endinterface

// File: rtl/vrf_xor_mp.sv
// Multiport vector register file: one XOR-encoded bank per write port, each bank
// replicated per reader, with zero-init sweep, read-after-write bypass and collision drop.
module vrf_xor_mp #(
    parameter int unsigned R_PORTS_NUM = 4,
    parameter int unsigned W_PORTS_NUM = 2,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned MEM_WIDTH   = 32
) (
    input logic         clk,
    input logic         rstn,
    vrf_xor_mp_if.slave vrf
);
    localparam int unsigned NUM_OF_BYTES = MEM_WIDTH / 8;
    localparam int unsigned AW           = $clog2(MEM_DEPTH);
    localparam int unsigned NCOPY        = R_PORTS_NUM + W_PORTS_NUM;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                                   r_state;
    logic [AW-1:0]                            r_cnt;
    logic                                     r_init_done;
    logic [MEM_WIDTH-1:0]                     r_mem [W_PORTS_NUM][NCOPY][MEM_DEPTH];

    logic [W_PORTS_NUM-1:0]                   r_s1_valid, r_s2_valid;
    logic [W_PORTS_NUM-1:0][AW-1:0]           r_s1_addr, r_s2_addr;
    logic [W_PORTS_NUM-1:0][NUM_OF_BYTES-1:0] r_s1_bwe, r_s2_bwe;
    logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0]    r_s1_din, r_s2_din, r_s2_oth;
    logic [W_PORTS_NUM-1:0]                   r_wcoll;

    logic [R_PORTS_NUM-1:0]                   r_rd_valid, r_rvalid;
    logic [R_PORTS_NUM-1:0][MEM_WIDTH-1:0]    r_rd_data, r_dout;

    logic                                     w_ready;
    logic [W_PORTS_NUM-1:0]                   w_drop, w_wacc;
    logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0]    w_enc, w_oth_nxt;
    logic [R_PORTS_NUM-1:0][MEM_WIDTH-1:0]    w_rd_nxt;

    assign w_ready = (r_state == ST_READY);
    assign w_enc   = r_s2_din ^ r_s2_oth;
    assign w_wacc  = vrf.wen_i & ~w_drop & {W_PORTS_NUM{w_ready}};

    // Same-cycle same-address writes: highest-index port wins, lower ones are dropped.
    always_comb begin
        w_drop = '0;
        for (int unsigned p = 0; p < W_PORTS_NUM; p++) begin
            for (int unsigned q = p + 1; q < W_PORTS_NUM; q++) begin
                if (vrf.wen_i[p] && vrf.wen_i[q] && (vrf.waddr_i[p] == vrf.waddr_i[q])) begin
                    w_drop[p] = 1'b1;
                end
            end
        end
    end

    // Other-bank XOR for stage-2 encoding, forwarding any bank word committing this edge.
    always_comb begin
        logic [MEM_WIDTH-1:0] w_bank;
        w_bank    = '0;
        w_oth_nxt = '0;
        for (int unsigned p = 0; p < W_PORTS_NUM; p++) begin
            for (int unsigned q = 0; q < W_PORTS_NUM; q++) begin
                if (q != p) begin
                    w_bank = r_mem[q][R_PORTS_NUM + p][r_s1_addr[p]];
                    for (int unsigned k = 0; k < NUM_OF_BYTES; k++) begin
                        if (r_s2_valid[q] && r_s2_bwe[q][k] && (r_s2_addr[q] == r_s1_addr[p])) begin
                            w_bank[k*8 +: 8] = w_enc[q][k*8 +: 8];
                        end
                    end
                    w_oth_nxt[p] = w_oth_nxt[p] ^ w_bank;
                end
            end
        end
    end

    // Logical read word, then stage-2 and (newer) stage-1 byte bypass.
    always_comb begin
        logic [MEM_WIDTH-1:0] w_word;
        w_word   = '0;
        w_rd_nxt = '0;
        for (int unsigned r = 0; r < R_PORTS_NUM; r++) begin
            w_word = '0;
            for (int unsigned b = 0; b < W_PORTS_NUM; b++) begin
                w_word = w_word ^ r_mem[b][r][vrf.raddr_i[r]];
            end
            for (int unsigned b = 0; b < W_PORTS_NUM; b++) begin
                for (int unsigned k = 0; k < NUM_OF_BYTES; k++) begin
                    if (r_s2_valid[b] && r_s2_bwe[b][k] && (r_s2_addr[b] == vrf.raddr_i[r])) begin
                        w_word[k*8 +: 8] = r_s2_din[b][k*8 +: 8];
                    end
                end
            end
            for (int unsigned b = 0; b < W_PORTS_NUM; b++) begin
                for (int unsigned k = 0; k < NUM_OF_BYTES; k++) begin
                    if (r_s1_valid[b] && r_s1_bwe[b][k] && (r_s1_addr[b] == vrf.raddr_i[r])) begin
                        w_word[k*8 +: 8] = r_s1_din[b][k*8 +: 8];
                    end
                end
            end
            w_rd_nxt[r] = w_word;
        end
    end

    // Init-sweep FSM, pipeline valids and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_s1_valid  <= '0;
            r_s2_valid  <= '0;
            r_wcoll     <= '0;
            r_rd_valid  <= '0;
            r_rvalid    <= '0;
            r_dout      <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == AW'(MEM_DEPTH - 1)) begin
                    r_state     <= ST_READY;
                    r_init_done <= 1'b1;
                end
            end else begin
                r_init_done <= 1'b1;
            end
            r_s1_valid <= w_wacc;
            r_s2_valid <= r_s1_valid;
            r_wcoll    <= vrf.wen_i & w_drop & {W_PORTS_NUM{w_ready}};
            r_rd_valid <= vrf.ren_i & {R_PORTS_NUM{w_ready}};
            r_rvalid   <= r_rd_valid;
            for (int unsigned r = 0; r < R_PORTS_NUM; r++) begin
                if (r_rd_valid[r]) begin
                    r_dout[r] <= r_rd_data[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        r_s1_addr <= vrf.waddr_i;
        r_s1_din  <= vrf.din_i;
        for (int unsigned p = 0; p < W_PORTS_NUM; p++) begin
            r_s1_bwe[p] <= vrf.bwe_i[p] & {NUM_OF_BYTES{vrf.wen_i[p]}};
        end
        r_s2_addr <= r_s1_addr;
        r_s2_din  <= r_s1_din;
        r_s2_bwe  <= r_s1_bwe;
        r_s2_oth  <= w_oth_nxt;
        r_rd_data <= w_rd_nxt;
    end

    // Bank storage: sweep clears all copies; commits are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int unsigned b = 0; b < W_PORTS_NUM; b++) begin
                for (int unsigned c = 0; c < NCOPY; c++) begin
                    if (r_state == ST_INIT) begin
                        r_mem[b][c][r_cnt] <= '0;
                    end else begin
                        for (int unsigned k = 0; k < NUM_OF_BYTES; k++) begin
                            if (r_s2_valid[b] && r_s2_bwe[b][k]) begin
                                r_mem[b][c][r_s2_addr[b]][k*8 +: 8] <= w_enc[b][k*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign vrf.dout_o       = r_dout;
    assign vrf.rvalid_o     = r_rvalid;
    assign vrf.init_done_o  = r_init_done;
    assign vrf.wcollision_o = r_wcoll;
endmodule

// File: tb/tb_vrf_xor_mp.sv
// Directed self-checking bench for vrf_xor_mp: init sweep, encoding, bypass, collisions, reset.
module tb_vrf_xor_mp;
    localparam int unsigned RP    = 4;
    localparam int unsigned WP    = 2;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rstn;
    int   n_tests = 0;
    int   n_fail  = 0;

    vrf_xor_mp_if #(.R_PORTS_NUM(RP), .W_PORTS_NUM(WP), .MEM_DEPTH(DEPTH), .MEM_WIDTH(WIDTH)) vif ();

    vrf_xor_mp #(.R_PORTS_NUM(RP), .W_PORTS_NUM(WP), .MEM_DEPTH(DEPTH), .MEM_WIDTH(WIDTH)) dut (
        .clk (clk),
        .rstn(rstn),
        .vrf (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vif.ren_i   = '0;
        vif.raddr_i = '0;
        vif.wen_i   = '0;
        vif.waddr_i = '0;
        vif.bwe_i   = '0;
        vif.din_i   = '0;
    endtask

    task automatic drive_wr(input int p, input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        vif.wen_i[p]   = 1'b1;
        vif.waddr_i[p] = a;
        vif.din_i[p]   = d;
        vif.bwe_i[p]   = be;
    endtask

    task automatic drive_rd(input int r, input logic [5:0] a);
        vif.ren_i[r]   = 1'b1;
        vif.raddr_i[r] = a;
    endtask

    task automatic test_reset();
        int cyc;
        bit bad;
        idle();
        rstn = 1'b0;
        tick();
        tick();
        n_tests++;
        if (vif.init_done_o !== 1'b0 || vif.rvalid_o !== 4'b0 || vif.wcollision_o !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: done=%b rvalid=%b wcoll=%b want 0/0000/00",
                     vif.init_done_o, vif.rvalid_o, vif.wcollision_o);
        end
        n_tests++;
        if (vif.dout_o !== '0) begin
            n_fail++;
            $display("FAIL reset_dout: got %h want 0", vif.dout_o);
        end
        // Traffic during the sweep must be ignored.
        rstn = 1'b1;
        vif.ren_i = '1;
        drive_wr(0, 6'd0, 32'hFFFF_FFFF, 4'hF);
        drive_wr(1, 6'd0, 32'h0F0F_0F0F, 4'hF);
        cyc = 0;
        bad = 1'b0;
        while (vif.init_done_o !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
            if (vif.rvalid_o !== 4'b0 || vif.wcollision_o !== 2'b0) bad = 1'b1;
        end
        idle();
        n_tests++;
        if (cyc != 64) begin
            n_fail++;
            $display("FAIL init_len: got %0d cycles want 64", cyc);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL init_ignore: got rvalid/wcoll activity during sweep want none");
        end
    endtask

    task automatic test_init_zero();
        for (int i = 0; i <= 16; i++) begin
            idle();
            if (i < 16) begin
                for (int r = 0; r < 4; r++) drive_rd(r, 6'(4 * i + r));
            end
            tick();
            if (i >= 1) begin
                n_tests++;
                if (vif.rvalid_o !== 4'hF || vif.dout_o !== '0) begin
                    n_fail++;
                    $display("FAIL zero_batch%0d: rvalid=%b dout=%h want 1111 / 0", i - 1, vif.rvalid_o, vif.dout_o);
                end
            end
        end
        tick();
        n_tests++;
        if (vif.rvalid_o !== 4'h0) begin
            n_fail++;
            $display("FAIL zero_strobe_end: rvalid=%b want 0000", vif.rvalid_o);
        end
    endtask

    task automatic test_basic_write();
        idle();
        drive_wr(0, 6'd5, 32'hDEAD_BEEF, 4'hF);
        drive_wr(1, 6'd9, 32'h1234_5678, 4'hF);
        tick();
        idle();
        n_tests++;
        if (vif.wcollision_o !== 2'b00) begin
            n_fail++;
            $display("FAIL distinct_nocoll: got %b want 00", vif.wcollision_o);
        end
        tick();
        tick();
        drive_rd(0, 6'd5);
        drive_rd(1, 6'd9);
        tick();
        idle();
        tick();
        n_tests++;
        if (vif.rvalid_o !== 4'b0011 || vif.dout_o[0] !== 32'hDEAD_BEEF || vif.dout_o[1] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL basic_rd: rvalid=%b d0=%h d1=%h want 0011 deadbeef 12345678",
                     vif.rvalid_o, vif.dout_o[0], vif.dout_o[1]);
        end
        tick();
        n_tests++;
        if (vif.rvalid_o !== 4'b0000 || vif.dout_o[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL dout_hold: rvalid=%b d0=%h want 0000 deadbeef", vif.rvalid_o, vif.dout_o[0]);
        end
    endtask

    task automatic test_bypass();
        idle();
        drive_wr(0, 6'd3, 32'hAABB_CCDD, 4'hF);
        tick();
        idle();
        tick();
        tick();
        tick();
        drive_wr(1, 6'd3, 32'h0000_0011, 4'b0001);
        tick();
        idle();
        drive_rd(0, 6'd3);
        tick();
        idle();
        tick();
        n_tests++;
        if (vif.rvalid_o !== 4'b0001 || vif.dout_o[0] !== 32'hAABB_CC11) begin
            n_fail++;
            $display("FAIL bypass_s1: rvalid=%b d0=%h want 0001 aabbcc11", vif.rvalid_o, vif.dout_o[0]);
        end
        tick();
        tick();
        drive_rd(2, 6'd3);
        tick();
        idle();
        tick();
        n_tests++;
        if (vif.dout_o[2] !== 32'hAABB_CC11) begin
            n_fail++;
            $display("FAIL bytewrite_mem: got %h want aabbcc11", vif.dout_o[2]);
        end
        // Older partial write in stage 2, newer overlapping partial write in stage 1.
        drive_wr(0, 6'd10, 32'h0000_BBBB, 4'b0011);
        tick();
        idle();
        drive_wr(1, 6'd10, 32'h00CC_CC00, 4'b0110);
        tick();
        idle();
        drive_rd(3, 6'd10);
        tick();
        idle();
        tick();
        n_tests++;
        if (vif.dout_o[3] !== 32'h00CC_CCBB) begin
            n_fail++;
            $display("FAIL bypass_merge: got %h want 00ccccbb", vif.dout_o[3]);
        end
        tick();
        tick();
        drive_rd(1, 6'd10);
        tick();
        idle();
        tick();
        n_tests++;
        if (vif.dout_o[1] !== 32'h00CC_CCBB) begin
            n_fail++;
            $display("FAIL merge_mem: got %h want 00ccccbb", vif.dout_o[1]);
        end
    endtask

    task automatic test_collision();
        idle();
        drive_wr(0, 6'd7, 32'h0000_1111, 4'hF);
        drive_wr(1, 6'd7, 32'h0000_2222, 4'hF);
        tick();
        idle();
        n_tests++;
        if (vif.wcollision_o !== 2'b01) begin
            n_fail++;
            $display("FAIL coll_pulse: got %b want 01", vif.wcollision_o);
        end
        tick();
        n_tests++;
        if (vif.wcollision_o !== 2'b00) begin
            n_fail++;
            $display("FAIL coll_one_cycle: got %b want 00", vif.wcollision_o);
        end
        tick();
        drive_rd(0, 6'd7);
        tick();
        idle();
        tick();
        n_tests++;
        if (vif.dout_o[0] !== 32'h0000_2222) begin
            n_fail++;
            $display("FAIL coll_data: got %h want 00002222", vif.dout_o[0]);
        end
        // Disjoint byte enables still drop the lower port entirely.
        drive_wr(0, 6'd8, 32'hFFFF_0000, 4'b1100);
        drive_wr(1, 6'd8, 32'h0000_AAAA, 4'b0011);
        tick();
        idle();
        n_tests++;
        if (vif.wcollision_o !== 2'b01) begin
            n_fail++;
            $display("FAIL coll_disjoint_pulse: got %b want 01", vif.wcollision_o);
        end
        tick();
        tick();
        drive_rd(2, 6'd8);
        tick();
        idle();
        tick();
        n_tests++;
        if (vif.dout_o[2] !== 32'h0000_AAAA) begin
            n_fail++;
            $display("FAIL coll_disjoint_data: got %h want 0000aaaa", vif.dout_o[2]);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        drive_wr(1, 6'd2, 32'h5555_5555, 4'hF);
        tick();
        idle();
        tick();
        tick();
        // cycle t: W0 write, read old; t+1: W1 write, read W0; t+2: read W1
        drive_wr(0, 6'd2, 32'h0102_0304, 4'hF);
        drive_rd(0, 6'd2);
        tick();
        idle();
        drive_wr(1, 6'd2, 32'hCAFE_F00D, 4'hF);
        drive_rd(1, 6'd2);
        tick();
        idle();
        drive_rd(2, 6'd2);
        n_tests++;
        if (vif.rvalid_o !== 4'b0001 || vif.dout_o[0] !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL raw_t: rvalid=%b d0=%h want 0001 55555555", vif.rvalid_o, vif.dout_o[0]);
        end
        tick();
        idle();
        n_tests++;
        if (vif.rvalid_o !== 4'b0010 || vif.dout_o[1] !== 32'h0102_0304) begin
            n_fail++;
            $display("FAIL raw_t1: rvalid=%b d1=%h want 0010 01020304", vif.rvalid_o, vif.dout_o[1]);
        end
        tick();
        n_tests++;
        if (vif.rvalid_o !== 4'b0100 || vif.dout_o[2] !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL raw_t2: rvalid=%b d2=%h want 0100 cafef00d", vif.rvalid_o, vif.dout_o[2]);
        end
        tick();
        tick();
        drive_rd(3, 6'd2);
        tick();
        idle();
        tick();
        n_tests++;
        if (vif.dout_o[3] !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL raw_mem: got %h want cafef00d", vif.dout_o[3]);
        end
        // One port, consecutive reads.
        drive_rd(3, 6'd5);
        tick();
        idle();
        drive_rd(3, 6'd9);
        tick();
        idle();
        n_tests++;
        if (vif.rvalid_o !== 4'b1000 || vif.dout_o[3] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL b2b_rd0: rvalid=%b d3=%h want 1000 deadbeef", vif.rvalid_o, vif.dout_o[3]);
        end
        tick();
        n_tests++;
        if (vif.rvalid_o !== 4'b1000 || vif.dout_o[3] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL b2b_rd1: rvalid=%b d3=%h want 1000 12345678", vif.rvalid_o, vif.dout_o[3]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        idle();
        drive_wr(0, 6'd20, 32'h0000_0001, 4'hF);
        drive_wr(1, 6'd21, 32'h0000_0002, 4'hF);
        drive_rd(0, 6'd5);
        tick();
        idle();
        drive_wr(0, 6'd22, 32'h0000_0003, 4'hF);
        tick();
        n_tests++;
        if (vif.dout_o[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL pre_reset_dout: got %h want deadbeef", vif.dout_o[0]);
        end
        idle();
        drive_wr(1, 6'd23, 32'h0000_0004, 4'hF);
        rstn = 1'b0;
        tick();
        idle();
        rstn = 1'b1;
        n_tests++;
        if (vif.dout_o !== '0 || vif.rvalid_o !== 4'b0 || vif.wcollision_o !== 2'b0 || vif.init_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: dout=%h rvalid=%b wcoll=%b done=%b want all 0",
                     vif.dout_o, vif.rvalid_o, vif.wcollision_o, vif.init_done_o);
        end
        cyc = 0;
        while (vif.init_done_o !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc != 64) begin
            n_fail++;
            $display("FAIL midreset_init_len: got %0d cycles want 64", cyc);
        end
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        test_reset();
        test_init_zero();
        test_basic_write();
        test_bypass();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_init_zero();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
